// File: rtl/soc_noc_lsu_read_responder.sv
// NoC target for LSU word reads: parses single/burst read requests, reads local memory one word at a time
// and streams back a READRESP packet. Malformed requests are swallowed and counted.
module soc_noc_lsu_read_responder #(
    parameter int         FLIT_WIDTH  = 32,
    parameter logic [4:0] TILE_ID     = 5'd0,
    parameter int         NOC_MAX_LEN = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [FLIT_WIDTH-1:0] noc_in_flit,
    input  logic                  noc_in_last,
    input  logic                  noc_in_valid,
    output logic                  noc_in_ready,
    output logic [FLIT_WIDTH-1:0] noc_out_flit,
    output logic                  noc_out_last,
    output logic                  noc_out_valid,
    input  logic                  noc_out_ready,
    output logic                  bus_req,
    output logic [31:0]           bus_addr,
    input  logic                  bus_ack,
    input  logic [31:0]           bus_rdata,
    input  logic                  bus_err,
    output logic [7:0]            drop_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_LEN,
        S_DROP,
        S_HDR,
        S_READ,
        S_SEND
    } state_t;

    localparam logic [2:0] CLASS_LSU  = 3'h2;
    localparam logic [2:0] MT_READREQ = 3'h0;
    localparam logic [2:0] MT_READRSP = 3'h1;
    localparam logic [5:0] MAX_BURST  = 6'(NOC_MAX_LEN - 1);

    state_t      state_q, state_d;
    logic [4:0]  src_q, src_d;
    logic        size_q, size_d;
    logic [31:0] addr_q, addr_d;
    logic [5:0]  count_q, count_d;
    logic [31:0] data_q, data_d;
    logic [7:0]  drop_cnt_q, drop_cnt_d;

    logic        in_hs;
    logic        out_hs;
    logic        drop;
    state_t      drop_next;
    logic [5:0]  req_len;
    logic        len_ok;

    // Address bits [1:0] are ignored on purpose: all accesses are word aligned.
    logic unused_bits;
    assign unused_bits = &{1'b0, noc_in_flit[1:0]};

    assign noc_in_ready = (state_q == S_IDLE) || (state_q == S_ADDR) ||
                          (state_q == S_LEN)  || (state_q == S_DROP);
    assign in_hs     = noc_in_valid && noc_in_ready;
    assign out_hs    = noc_out_valid && noc_out_ready;
    assign drop_next = noc_in_last ? S_IDLE : S_DROP;
    assign req_len   = noc_in_flit[5:0];
    assign len_ok    = (req_len != 6'd0) && (req_len <= MAX_BURST);

    assign bus_req  = (state_q == S_READ);
    assign bus_addr = addr_q;
    assign drop_cnt = drop_cnt_q;

    always_comb begin
        state_d       = state_q;
        src_d         = src_q;
        size_d        = size_q;
        addr_d        = addr_q;
        count_d       = count_q;
        data_d        = data_q;
        drop_cnt_d    = drop_cnt_q;
        drop          = 1'b0;
        noc_out_valid = 1'b0;
        noc_out_last  = 1'b0;
        noc_out_flit  = '0;

        case (state_q)
            S_IDLE: begin
                if (in_hs) begin
                    if ((noc_in_flit[26:24] != CLASS_LSU) || (noc_in_flit[18:16] != MT_READREQ) ||
                        noc_in_last) begin
                        drop    = 1'b1;
                        state_d = drop_next;
                    end else begin
                        src_d   = noc_in_flit[23:19];
                        size_d  = noc_in_flit[15];
                        state_d = S_ADDR;
                    end
                end
            end
            S_ADDR: begin
                if (in_hs) begin
                    addr_d = {noc_in_flit[31:2], 2'b00};
                    if (!size_q && noc_in_last) begin
                        count_d = 6'd1;
                        state_d = S_HDR;
                    end else if (size_q && !noc_in_last) begin
                        state_d = S_LEN;
                    end else begin
                        drop    = 1'b1;
                        state_d = drop_next;
                    end
                end
            end
            S_LEN: begin
                if (in_hs) begin
                    if (noc_in_last && len_ok) begin
                        count_d = req_len;
                        state_d = S_HDR;
                    end else begin
                        drop    = 1'b1;
                        state_d = drop_next;
                    end
                end
            end
            S_DROP: begin
                if (in_hs && noc_in_last) begin
                    state_d = S_IDLE;
                end
            end
            S_HDR: begin
                noc_out_valid = 1'b1;
                noc_out_flit  = {src_q, CLASS_LSU, TILE_ID, MT_READRSP, size_q, 15'h0};
                if (out_hs) begin
                    state_d = S_READ;
                end
            end
            S_READ: begin
                // A failed read still produces a data flit so the packet length stays as announced.
                if (bus_ack) begin
                    data_d  = bus_rdata;
                    state_d = S_SEND;
                end else if (bus_err) begin
                    data_d  = 32'h0;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                noc_out_valid = 1'b1;
                noc_out_last  = (count_q == 6'd1);
                noc_out_flit  = data_q;
                if (out_hs) begin
                    count_d = count_q - 6'd1;
                    addr_d  = addr_q + 32'd4;
                    state_d = (count_q == 6'd1) ? S_IDLE : S_READ;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (drop && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            src_q      <= 5'd0;
            size_q     <= 1'b0;
            addr_q     <= 32'h0;
            count_q    <= 6'd0;
            data_q     <= 32'h0;
            drop_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            size_q     <= size_d;
            addr_q     <= addr_d;
            count_q    <= count_d;
            data_q     <= data_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

endmodule

// File: tb/tb_soc_noc_lsu_read_responder.sv
// Randomized bench: request packets go in, a packet-level model predicts response flits, bus addresses
// and the drop count; a randomly stalling bus and sink exercise backpressure.
module tb_soc_noc_lsu_read_responder;

    localparam logic [4:0] TILE = 5'd3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] noc_in_flit = '0;
    logic        noc_in_last = 1'b0;
    logic        noc_in_valid = 1'b0;
    logic        noc_in_ready;
    logic [31:0] noc_out_flit;
    logic        noc_out_last;
    logic        noc_out_valid;
    logic        noc_out_ready = 1'b0;
    logic        bus_req;
    logic [31:0] bus_addr;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = '0;
    logic        bus_err = 1'b0;
    logic [7:0]  drop_cnt;

    soc_noc_lsu_read_responder #(
        .FLIT_WIDTH (32),
        .TILE_ID    (TILE),
        .NOC_MAX_LEN(32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .noc_in_flit  (noc_in_flit),
        .noc_in_last  (noc_in_last),
        .noc_in_valid (noc_in_valid),
        .noc_in_ready (noc_in_ready),
        .noc_out_flit (noc_out_flit),
        .noc_out_last (noc_out_last),
        .noc_out_valid(noc_out_valid),
        .noc_out_ready(noc_out_ready),
        .bus_req      (bus_req),
        .bus_addr     (bus_addr),
        .bus_ack      (bus_ack),
        .bus_rdata    (bus_rdata),
        .bus_err      (bus_err),
        .drop_cnt     (drop_cnt)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [32:0] exp_q[$];
    logic [31:0] exp_addr_q[$];
    int          exp_drops = 0;
    logic [31:0] pkt[$];
    logic [31:0] err_addr = 32'h0000_3004;
    logic        hold_low = 1'b0;
    logic        stall_seen = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rd_fn(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] mk_hdr(input logic [2:0] cls, input logic [4:0] src,
                                           input logic [2:0] mt, input logic sz);
        logic [31:0] r;
        r = $urandom;
        return {r[31:27], cls, src, mt, sz, r[14:0]};
    endfunction

    // Packet-level model: a request is good only if class/type match and the flit count fits its size.
    task automatic model_pkt();
        logic [31:0] h, a, lf;
        logic [5:0]  len;
        int          n, cnt;
        bit          ok;
        h  = pkt[0];
        n  = pkt.size();
        ok = (h[26:24] == 3'd2) && (h[18:16] == 3'd0);
        cnt = 1;
        if (ok) begin
            if (!h[15]) begin
                ok = (n == 2);
            end else if (n != 3) begin
                ok = 1'b0;
            end else begin
                lf  = pkt[2];
                len = lf[5:0];
                ok  = (len >= 6'd1) && (len <= 6'd31);
                cnt = int'(len);
            end
        end
        if (ok) begin
            exp_q.push_back({1'b0, h[23:19], 3'd2, TILE, 3'd1, h[15], 15'd0});
            a = pkt[1] & 32'hFFFF_FFFC;
            for (int i = 0; i < cnt; i++) begin
                exp_addr_q.push_back(a);
                exp_q.push_back({(i == cnt - 1), (a == err_addr) ? 32'h0 : rd_fn(a)});
                a = a + 32'd4;
            end
        end else if (exp_drops < 255) begin
            exp_drops++;
        end
    endtask

    task automatic send_flit(input logic [31:0] f, input logic l);
        int n;
        bit acc;
        noc_in_valid = 1'b1;
        noc_in_flit  = f;
        noc_in_last  = l;
        n = 0;
        do begin
            @(negedge clk);
            acc = noc_in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 3000);
        if (!acc) chk("in_accept_timeout", 64'(acc), 64'd1);
        noc_in_valid = 1'b0;
        noc_in_last  = 1'b0;
    endtask

    task automatic send_pkt();
        model_pkt();
        for (int i = 0; i < pkt.size(); i++) send_flit(pkt[i], (i == pkt.size() - 1));
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || exp_addr_q.size() != 0) && n < 8000) begin
            @(posedge clk);
            n++;
        end
        chk({tag, "_pending"}, 64'(exp_q.size()), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        chk({tag, "_in_ready"}, 64'(noc_in_ready), 64'd1);
        chk({tag, "_drop_cnt"}, 64'(drop_cnt), 64'(exp_drops));
    endtask

    always @(posedge clk) begin
        #1;
        noc_out_ready = hold_low ? 1'b0 : ($urandom_range(0, 3) != 0);
    end

    // Memory model: random ack latency, error at one fixed address, garbage data on error.
    always @(posedge clk) begin
        #1;
        if (bus_req && $urandom_range(0, 2) != 0) begin
            bus_err   = (bus_addr == err_addr);
            bus_ack   = (bus_addr != err_addr);
            bus_rdata = (bus_addr == err_addr) ? $urandom : rd_fn(bus_addr);
        end else begin
            bus_ack   = 1'b0;
            bus_err   = 1'b0;
            bus_rdata = $urandom;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            stall_seen = 1'b0;
        end else begin
            if (noc_out_valid) chk("bus_req_while_out", 64'(bus_req), 64'd0);
            if (stall_seen) chk("hold_valid", 64'(noc_out_valid), 64'd1);
            stall_seen = noc_out_valid && !noc_out_ready;
            if (noc_out_valid && noc_out_ready) begin
                if (exp_q.size() == 0) chk("unexpected_flit", 64'(exp_q.size()), 64'd1);
                else chk("out_flit", {noc_out_last, noc_out_flit}, exp_q.pop_front());
            end
            if (bus_req && (bus_ack || bus_err)) begin
                if (exp_addr_q.size() == 0) chk("unexpected_read", 64'(exp_addr_q.size()), 64'd1);
                else chk("bus_addr", bus_addr, exp_addr_q.pop_front());
            end
        end
    end

    initial begin
        int          kind, n;
        logic [31:0] r;
        logic [2:0]  cls, mt;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(noc_out_valid), 64'd0);
        chk("rst_out_last", 64'(noc_out_last), 64'd0);
        chk("rst_out_flit", noc_out_flit, 64'd0);
        chk("rst_bus_req", 64'(bus_req), 64'd0);
        chk("rst_bus_addr", bus_addr, 64'd0);
        chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_ready", 64'(noc_in_ready), 64'd1);

        pkt = '{mk_hdr(3'd2, 5'd5, 3'd0, 1'b0), 32'h0000_1003};
        send_pkt();
        wait_idle("single");

        pkt = '{mk_hdr(3'd2, 5'd9, 3'd0, 1'b1), 32'h0000_2000, 32'h0000_0004};
        send_pkt();
        wait_idle("burst4");

        hold_low = 1'b1;
        pkt = '{mk_hdr(3'd2, 5'd17, 3'd0, 1'b1), 32'h0000_2400, 32'h0000_0003};
        send_pkt();
        repeat (10) @(posedge clk);
        hold_low = 1'b0;
        wait_idle("backpressure");

        pkt = '{mk_hdr(3'd1, 5'd2, 3'd0, 1'b0), 32'h0000_4000, 32'h0000_0001};
        send_pkt();
        pkt = '{mk_hdr(3'd2, 5'd2, 3'd0, 1'b1), 32'h0000_4000, 32'h0000_0000};
        send_pkt();
        pkt = '{mk_hdr(3'd2, 5'd2, 3'd0, 1'b0)};
        send_pkt();
        wait_idle("drops");
        chk("drops_three", 64'(drop_cnt), 64'd3);

        pkt = '{mk_hdr(3'd2, 5'd30, 3'd0, 1'b1), 32'h0000_3000, 32'h0000_0003};
        send_pkt();
        wait_idle("bus_err");

        pkt = '{mk_hdr(3'd2, 5'd31, 3'd0, 1'b1), 32'hFFFF_FFFA, 32'h0000_0003};
        send_pkt();
        wait_idle("wrap");

        for (int p = 0; p < 60; p++) begin
            kind = $urandom_range(0, 9);
            r    = $urandom;
            if (kind <= 3) begin
                pkt = '{mk_hdr(3'd2, r[4:0], 3'd0, 1'b0), $urandom};
            end else if (kind <= 6) begin
                n   = (kind == 6) ? $urandom_range(1, 31) : $urandom_range(1, 6);
                pkt = '{mk_hdr(3'd2, r[4:0], 3'd0, 1'b1), $urandom, {r[31:6], 6'(n)}};
            end else if (kind == 7) begin
                cls = r[10:8];
                mt  = r[13:11];
                if (cls == 3'd2 && mt == 3'd0) mt = 3'd4;
                pkt = '{mk_hdr(cls, r[4:0], mt, r[5]), $urandom};
                if (r[5]) pkt.push_back(32'd2);
            end else if (kind == 8) begin
                n   = r[6] ? 0 : $urandom_range(32, 63);
                pkt = '{mk_hdr(3'd2, r[4:0], 3'd0, 1'b1), $urandom, {r[31:6], 6'(n)}};
            end else begin
                if (r[7]) pkt = '{mk_hdr(3'd2, r[4:0], 3'd0, 1'b0), $urandom, $urandom};
                else pkt = '{mk_hdr(3'd2, r[4:0], 3'd0, 1'b1), $urandom};
            end
            send_pkt();
        end
        wait_idle("random");

        pkt = '{mk_hdr(3'd2, 5'd12, 3'd0, 1'b1), 32'h0000_5000, 32'h0000_0008};
        send_pkt();
        n = 0;
        while (!bus_req && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("reached_read", 64'(bus_req), 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_bus_req", 64'(bus_req), 64'd0);
        chk("midrst_out_valid", 64'(noc_out_valid), 64'd0);
        chk("midrst_out_flit", noc_out_flit, 64'd0);
        chk("midrst_drop_cnt", 64'(drop_cnt), 64'd0);
        exp_q.delete();
        exp_addr_q.delete();
        exp_drops = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        pkt = '{mk_hdr(3'd2, 5'd7, 3'd0, 1'b0), 32'h0000_6004};
        send_pkt();
        wait_idle("after_reset");

        for (int p = 0; p < 260; p++) begin
            pkt = '{mk_hdr(3'd2, 5'd1, 3'd0, 1'b0)};
            send_pkt();
        end
        wait_idle("saturate");
        chk("drop_saturated", 64'(drop_cnt), 64'd255);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
